// File: rtl/nios2_nios2_gen2_0_cpu_debug_mem_ctrl.sv
// JTAG/Avalon debug-RAM access stage: executes ocimem strobes against a shared
// 2^ADDR_W x DATA_W RAM, with JTAG taking priority over the Avalon slave port.
module nios2_nios2_gen2_0_cpu_debug_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  debugaccess,
  input  logic [ADDR_W:0]       avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     MonDReg,
  output logic [ADDR_W-1:0]     MonAReg
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {J_IDLE, J_RD, J_RDL, J_WR} jst_e;
  typedef enum logic       {A_IDLE, A_RD}               ast_e;

  jst_e              jst_q, jst_d;
  ast_e              ast_q, ast_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [DATA_W-1:0] mon_d_q, mon_d_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W:0]   areg_q, areg_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q, ram_wd;
  logic [ADDR_W-1:0] ram_addr;
  logic [NB-1:0]     ram_we;

  logic       any_stb, jbusy, blocked;
  logic [1:0] n_stb;
  logic       unused_ok;

  assign any_stb = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign n_stb   = {1'b0, take_action_ocimem_a} + {1'b0, take_no_action_ocimem_a}
                 + {1'b0, take_action_ocimem_b};
  assign jbusy   = (jst_q != J_IDLE);
  assign blocked = (avs_read | avs_write) & (jbusy | any_stb);
  assign unused_ok = &{1'b0, jdo[37:35], jdo[2:0]};

  always_comb begin
    jst_d           = jst_q;
    ast_d           = ast_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    areg_d          = areg_q;
    err_d           = err_q;
    ram_addr        = avs_address[ADDR_W-1:0];
    ram_we          = '0;
    ram_wd          = avs_writedata;
    avs_waitrequest = 1'b0;

    case (jst_q)
      J_IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          jst_d   = J_WR;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[17:10];
          if (jdo[34]) jst_d = J_RD;
        end else if (take_no_action_ocimem_a) begin
          jst_d = J_RD;
        end
        if (n_stb > 2'd1) err_d = 1'b1;
      end
      J_RD: begin
        ram_addr = mon_a_q;
        jst_d    = J_RDL;
        if (any_stb) err_d = 1'b1;
      end
      J_RDL: begin
        mon_d_d = ram_q;
        mon_a_d = mon_a_q + 1'b1;
        jst_d   = J_IDLE;
        if (any_stb) err_d = 1'b1;
      end
      J_WR: begin
        ram_addr = mon_a_q;
        ram_we   = '1;
        ram_wd   = wdata_q;
        mon_a_d  = mon_a_q + 1'b1;
        jst_d    = J_IDLE;
        if (any_stb) err_d = 1'b1;
      end
      default: jst_d = J_IDLE;
    endcase

    // Avalon only touches the RAM port while JTAG is idle and quiet, so the
    // RAM address/write muxing above never collides with it.
    case (ast_q)
      A_IDLE: begin
        if (blocked) begin
          avs_waitrequest = 1'b1;
        end else if (avs_read) begin
          avs_waitrequest = 1'b1;
          areg_d          = avs_address;
          ast_d           = A_RD;
        end else if (avs_write) begin
          if (!avs_address[ADDR_W]) begin
            if (debugaccess) ram_we = avs_byteenable;
          end else if (avs_address[ADDR_W-1:0] == '0 && avs_writedata[1]) begin
            err_d = 1'b0;
          end
        end
      end
      A_RD: begin
        ast_d = A_IDLE;
        if (!areg_q[ADDR_W]) begin
          rdata_d = ram_q;
        end else begin
          case (areg_q[ADDR_W-1:0])
            ADDR_W'(0): rdata_d = {{(DATA_W-2){1'b0}}, err_q, jbusy};
            ADDR_W'(1): rdata_d = mon_d_q;
            default:    rdata_d = '0;
          endcase
        end
      end
      default: ast_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jst_q   <= J_IDLE;
      ast_q   <= A_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      areg_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      jst_q   <= jst_d;
      ast_q   <= ast_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      areg_q  <= areg_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wd[b*8 +: 8];
    ram_q <= mem[ram_addr];
  end

  assign avs_readdata = rdata_q;
  assign MonDReg      = mon_d_q;
  assign MonAReg      = mon_a_q;

endmodule

// File: tb/tb_nios2_nios2_gen2_0_cpu_debug_mem_ctrl.sv
// Directed bench for the debug-memory controller: JTAG read/write latency,
// wrap, Avalon arbitration, byte enables, sticky error and mid-write reset.
module tb_nios2_nios2_gen2_0_cpu_debug_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        st_a, st_na, st_b, debugaccess;
  logic [8:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata, MonDReg;
  logic        avs_waitrequest;
  logic [7:0]  MonAReg;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;
  int cyc;

  always #5 clk = ~clk;

  nios2_nios2_gen2_0_cpu_debug_mem_ctrl dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(st_a), .take_no_action_ocimem_a(st_na),
    .take_action_ocimem_b(st_b), .debugaccess(debugaccess),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [37:0] jaddr(input logic [7:0] a, input logic r);
    logic [37:0] j;
    j = '0; j[17:10] = a; j[34] = r;
    return j;
  endfunction

  function automatic logic [37:0] jdat(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  // one JTAG strobe held for exactly one cycle; returns at cycle N+1
  task automatic jstb(input logic a, input logic na, input logic b, input logic [37:0] j);
    jdo = j; st_a = a; st_na = na; st_b = b;
    tick();
    st_a = 0; st_na = 0; st_b = 0;
  endtask

  task automatic avs_rd(input logic [8:0] addr, output logic [31:0] d, output int n);
    logic w;
    avs_address = addr; avs_read = 1; n = 0;
    do begin
      n++; #1 w = avs_waitrequest; @(posedge clk); #1;
    end while (w && n < 20);
    avs_read = 0; d = avs_readdata;
    if (w) chk("avs_rd_timeout", 32'(n), 32'd0);
  endtask

  task automatic avs_wr(input logic [8:0] addr, input logic [31:0] d, input logic [3:0] be);
    logic w; int n;
    avs_address = addr; avs_writedata = d; avs_byteenable = be; avs_write = 1; n = 0;
    do begin
      n++; #1 w = avs_waitrequest; @(posedge clk); #1;
    end while (w && n < 20);
    avs_write = 0;
    if (w) chk("avs_wr_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    reset_n = 0; jdo = '0; st_a = 0; st_na = 0; st_b = 0; debugaccess = 1;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    repeat (3) tick();
    reset_n = 1;
    tick();

    // reset state
    chk("rst_mona", 32'(MonAReg), 32'h0);
    chk("rst_mond", MonDReg, 32'h0);
    chk("rst_wait", 32'(avs_waitrequest), 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);
    avs_rd(9'h100, rd, cyc);
    chk("rst_status", rd, 32'h0);
    chk("rd_latency", 32'(cyc), 32'd2);

    // address load without read, then JTAG write with increment
    jstb(1, 0, 0, jaddr(8'h10, 0));
    chk("aload_mona", 32'(MonAReg), 32'h10);
    jstb(0, 0, 1, jdat(32'hDEADBEEF));
    tick();
    chk("wr_mona_inc", 32'(MonAReg), 32'h11);
    avs_rd(9'h010, rd, cyc);
    chk("wr_ram", rd, 32'hDEADBEEF);
    chk("wr_rd_latency", 32'(cyc), 32'd2);

    // JTAG read at 0xFF with wrap, then no-action read at 0x00
    avs_wr(9'h0FF, 32'hCAFEF00D, 4'hF);
    avs_wr(9'h000, 32'h0BADF00D, 4'hF);
    jstb(1, 0, 0, jaddr(8'hFF, 1));
    chk("rd_n1_mond", MonDReg, 32'h0);
    tick(); tick();
    chk("rd_mond_ff", MonDReg, 32'hCAFEF00D);
    chk("rd_mona_wrap", 32'(MonAReg), 32'h00);
    jstb(0, 1, 0, '0);
    tick(); tick();
    chk("rd_mond_00", MonDReg, 32'h0BADF00D);
    chk("rd_mona_01", 32'(MonAReg), 32'h01);
    avs_rd(9'h101, rd, cyc);
    chk("reg_mond", rd, 32'h0BADF00D);

    // Avalon write contending with a JTAG write strobe
    jstb(1, 0, 0, jaddr(8'h40, 0));
    jdo = jdat(32'h11112222); st_b = 1;
    avs_address = 9'h020; avs_writedata = 32'hA5A5A5A5; avs_byteenable = 4'hF; avs_write = 1;
    #1 chk("cont_wait_n", 32'(avs_waitrequest), 32'h1);
    @(posedge clk); #1; st_b = 0;
    #1 chk("cont_wait_n1", 32'(avs_waitrequest), 32'h1);
    @(posedge clk); #1;
    #1 chk("cont_wait_n2", 32'(avs_waitrequest), 32'h0);
    @(posedge clk); #1; avs_write = 0;
    avs_rd(9'h020, rd, cyc);
    chk("cont_avs_ram", rd, 32'hA5A5A5A5);
    avs_rd(9'h040, rd, cyc);
    chk("cont_jtag_ram", rd, 32'h11112222);
    chk("cont_mona", 32'(MonAReg), 32'h41);

    // byte enables and debugaccess gating
    avs_wr(9'h030, 32'hFFFFFFFF, 4'hF);
    avs_wr(9'h030, 32'h12345678, 4'b0011);
    avs_rd(9'h030, rd, cyc);
    chk("be_mask", rd, 32'hFFFF5678);
    debugaccess = 0;
    avs_wr(9'h030, 32'h00000000, 4'hF);
    debugaccess = 1;
    avs_rd(9'h030, rd, cyc);
    chk("dbgacc_off", rd, 32'hFFFF5678);

    // strobe during a JTAG read is dropped and sets err
    jstb(1, 0, 0, jaddr(8'h50, 1));
    jstb(0, 1, 0, '0);
    tick();
    chk("drop_mona", 32'(MonAReg), 32'h51);
    avs_rd(9'h100, rd, cyc);
    chk("err_set", rd, 32'h2);
    avs_wr(9'h100, 32'h2, 4'hF);
    avs_rd(9'h100, rd, cyc);
    chk("err_clr", rd, 32'h0);

    // simultaneous strobes: ocimem_b wins, err set
    jstb(1, 0, 1, jdat(32'h00000077));
    tick();
    chk("simul_mona", 32'(MonAReg), 32'h52);
    avs_rd(9'h100, rd, cyc);
    chk("simul_err", rd, 32'h2);
    avs_rd(9'h051, rd, cyc);
    chk("simul_ram", rd, 32'h77);
    avs_rd(9'h1F0, rd, cyc);
    chk("unmapped", rd, 32'h0);

    // reset during J_WR: write not committed
    avs_wr(9'h070, 32'h0, 4'hF);
    jstb(1, 0, 0, jaddr(8'h70, 0));
    jstb(0, 0, 1, jdat(32'h99));
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    chk("rst_mid_mona", 32'(MonAReg), 32'h0);
    avs_rd(9'h100, rd, cyc);
    chk("rst_mid_err", rd, 32'h0);
    avs_rd(9'h070, rd, cyc);
    chk("rst_mid_ram", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
